// File: rtl/alu_ctrl_idex.sv
// D-stage main/ALU control decode registered into E (1-cycle latency); StallE holds, FlushE/reset load a bubble.
// Optional registered IllegalE output enabled by defining ALU_CTRL_ILLEGAL_EN.
module alu_ctrl_idex #(
    parameter int                   ALUCTRL_W  = 4,
    parameter logic [ALUCTRL_W-1:0] BUBBLE_ALU = 4'b0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           OpD,
    input  logic [5:0]           FunctD,
    input  logic                 StallE,
    input  logic                 FlushE,
    output logic                 BranchD,
    output logic                 JumpD,
    output logic                 RegWriteE,
    output logic                 MemtoRegE,
    output logic                 MemWriteE,
    output logic                 ALUSrcE,
    output logic                 RegDstE,
    output logic                 ImmZeroExtE,
    output logic [ALUCTRL_W-1:0] ALUControlE
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    output logic                 IllegalE
`endif
);

    localparam logic [ALUCTRL_W-1:0] ALU_AND   = 4'b0000;
    localparam logic [ALUCTRL_W-1:0] ALU_OR    = 4'b0001;
    localparam logic [ALUCTRL_W-1:0] ALU_ADD   = 4'b0010;
    localparam logic [ALUCTRL_W-1:0] ALU_SUB   = 4'b0110;
    localparam logic [ALUCTRL_W-1:0] ALU_SLT   = 4'b0111;
    localparam logic [ALUCTRL_W-1:0] ALU_NOR   = 4'b1100;
    localparam logic [ALUCTRL_W-1:0] ALU_UNDEF = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef struct packed {
        logic                 reg_write;
        logic                 mem_to_reg;
        logic                 mem_write;
        logic                 alu_src;
        logic                 reg_dst;
        logic                 imm_zext;
        logic [ALUCTRL_W-1:0] alu;
    } ctrl_t;

    localparam ctrl_t C_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0,
                                   alu_src: 1'b0, reg_dst: 1'b0, imm_zext: 1'b0,
                                   alu: BUBBLE_ALU};

    ctrl_t w_dec;
    logic  w_branch;
    logic  w_jump;
    ctrl_t r_ctrl;

    always_comb begin
        w_dec    = '0;
        w_dec.alu = ALU_UNDEF;
        w_branch = 1'b0;
        w_jump   = 1'b0;
        case (OpD)
            OP_RTYPE: begin
                w_dec.reg_write = 1'b1;
                w_dec.reg_dst   = 1'b1;
                case (FunctD)
                    6'b100000, 6'b100001: w_dec.alu = ALU_ADD;
                    6'b100010, 6'b100011: w_dec.alu = ALU_SUB;
                    6'b100100:            w_dec.alu = ALU_AND;
                    6'b100101:            w_dec.alu = ALU_OR;
                    6'b100111:            w_dec.alu = ALU_NOR;
                    6'b101010:            w_dec.alu = ALU_SLT;
                    default:              w_dec.reg_write = 1'b0;
                endcase
            end
            OP_LW: begin
                w_dec.alu        = ALU_ADD;
                w_dec.reg_write  = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_dec.alu_src    = 1'b1;
            end
            OP_SW: begin
                w_dec.alu       = ALU_ADD;
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                w_dec.alu = ALU_SUB;
                w_branch  = 1'b1;
            end
            OP_ADDI: begin
                w_dec.alu       = ALU_ADD;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
            end
            OP_SLTI: begin
                w_dec.alu       = ALU_SLT;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
            end
            OP_ANDI: begin
                w_dec.alu       = ALU_AND;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.imm_zext  = 1'b1;
            end
            OP_ORI: begin
                w_dec.alu       = ALU_OR;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.imm_zext  = 1'b1;
            end
            OP_J: begin
                w_dec.alu = ALU_ADD;
                w_jump    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl <= C_BUBBLE;
        end else if (FlushE) begin
            r_ctrl <= C_BUBBLE;
        end else if (!StallE) begin
            r_ctrl <= w_dec;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_EN
    // UNDEF is produced exactly for unknown opcodes and undefined R-type functs.
    logic r_illegal;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (FlushE) begin
            r_illegal <= 1'b0;
        end else if (!StallE) begin
            r_illegal <= (w_dec.alu == ALU_UNDEF);
        end
    end
    assign IllegalE = r_illegal;
`endif

    assign BranchD     = w_branch;
    assign JumpD       = w_jump;
    assign RegWriteE   = r_ctrl.reg_write;
    assign MemtoRegE   = r_ctrl.mem_to_reg;
    assign MemWriteE   = r_ctrl.mem_write;
    assign ALUSrcE     = r_ctrl.alu_src;
    assign RegDstE     = r_ctrl.reg_dst;
    assign ImmZeroExtE = r_ctrl.imm_zext;
    assign ALUControlE = r_ctrl.alu;

endmodule

// File: tb/tb_alu_ctrl_idex.sv
// Bench for alu_ctrl_idex: directed scenarios plus randomized traffic against a table-driven reference.
// Checks IllegalE as well when ALU_CTRL_ILLEGAL_EN is defined.
module tb_alu_ctrl_idex;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] OpD = '0;
    logic [5:0] FunctD = '0;
    logic       StallE = 1'b0;
    logic       FlushE = 1'b0;
    logic       BranchD, JumpD, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ImmZeroExtE;
    logic [3:0] ALUControlE;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic       IllegalE;
`endif

    alu_ctrl_idex dut (
        .clk(clk), .reset(reset), .OpD(OpD), .FunctD(FunctD),
        .StallE(StallE), .FlushE(FlushE),
        .BranchD(BranchD), .JumpD(JumpD),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ImmZeroExtE(ImmZeroExtE),
        .ALUControlE(ALUControlE)
`ifdef ALU_CTRL_ILLEGAL_EN
        , .IllegalE(IllegalE)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected control bundle: what each instruction means, not how it is decoded.
    typedef struct packed {
        bit       rw, m2r, mw, src, dst, zx, ill, br, j;
        bit [3:0] alu;
    } ref_t;

    localparam ref_t BUBBLE = '0;

    function automatic ref_t ref_decode(input logic [5:0] op, input logic [5:0] fn);
        ref_t r = '0;
        r.alu = 4'hF;
        r.ill = 1'b1;
        if (op == 6'h00) begin
            r.dst = 1'b1;
            r.ill = 1'b0;
            r.rw  = 1'b1;
            if (fn == 6'h20 || fn == 6'h21)      r.alu = 4'h2;
            else if (fn == 6'h22 || fn == 6'h23) r.alu = 4'h6;
            else if (fn == 6'h24)                r.alu = 4'h0;
            else if (fn == 6'h25)                r.alu = 4'h1;
            else if (fn == 6'h27)                r.alu = 4'hC;
            else if (fn == 6'h2A)                r.alu = 4'h7;
            else begin r.rw = 1'b0; r.ill = 1'b1; end
        end else if (op == 6'h23) begin r = '0; r.alu = 4'h2; r.rw = 1; r.m2r = 1; r.src = 1; end
        else if (op == 6'h2B)     begin r = '0; r.alu = 4'h2; r.mw = 1; r.src = 1; end
        else if (op == 6'h04)     begin r = '0; r.alu = 4'h6; r.br = 1; end
        else if (op == 6'h08)     begin r = '0; r.alu = 4'h2; r.rw = 1; r.src = 1; end
        else if (op == 6'h0A)     begin r = '0; r.alu = 4'h7; r.rw = 1; r.src = 1; end
        else if (op == 6'h0C)     begin r = '0; r.alu = 4'h0; r.rw = 1; r.src = 1; r.zx = 1; end
        else if (op == 6'h0D)     begin r = '0; r.alu = 4'h1; r.rw = 1; r.src = 1; r.zx = 1; end
        else if (op == 6'h02)     begin r = '0; r.alu = 4'h2; r.j = 1; end
        return r;
    endfunction

    ref_t e_exp = BUBBLE;

    task automatic check_e(input string tag);
        chk(tag, {22'd0, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ImmZeroExtE, ALUControlE},
                 {22'd0, e_exp.rw, e_exp.m2r, e_exp.mw, e_exp.src, e_exp.dst, e_exp.zx, e_exp.alu});
`ifdef ALU_CTRL_ILLEGAL_EN
        chk({tag, "_ill"}, {31'd0, IllegalE}, {31'd0, e_exp.ill});
`endif
    endtask

    task automatic check_d(input string tag);
        ref_t d;
        #1;
        d = ref_decode(OpD, FunctD);
        chk(tag, {30'd0, BranchD, JumpD}, {30'd0, d.br, d.j});
    endtask

    // Advance one clock, apply the pipeline-register rules to the model, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        if (reset || FlushE) e_exp = BUBBLE;
        else if (!StallE)    e_exp = ref_decode(OpD, FunctD);
        #1;
        check_e(tag);
    endtask

    initial begin
        logic [5:0] sweep_fn [6];
        logic [3:0] sweep_alu[6];
        logic [5:0] op_tab   [9];
        logic [5:0] rfn_tab  [8];
        sweep_fn  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        sweep_alu = '{4'h2, 4'h6, 4'h0, 4'h1, 4'hC, 4'h7};
        op_tab    = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h02};
        rfn_tab   = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};

        // Reset state, observed before any clock edge.
        #2 reset = 1'b1;
        #1 check_e("rst_init");
        step("rst_hold");

        // Load something, then assert reset between edges.
        reset = 1'b0; OpD = 6'h23;
        step("pre_arst");
        #2 reset = 1'b1;
        #1 e_exp = BUBBLE;
        check_e("arst_immediate");
        chk("arst_alu", {28'd0, ALUControlE}, 32'h0);
        OpD = 6'h00; FunctD = 6'h22;
        #1 reset = 1'b0;
        step("rst_release_sub");
        chk("rel_sub_alu", {28'd0, ALUControlE}, 32'h6);
        chk("rel_sub_rw",  {31'd0, RegWriteE}, 32'h1);

        // lw then sw.
        OpD = 6'h23;
        step("lw");
        chk("lw_m2r", {31'd0, MemtoRegE}, 32'h1);
        OpD = 6'h2B;
        step("sw");
        chk("sw_mw", {30'd0, MemWriteE, RegWriteE}, 32'h2);

        // ori, then stall three cycles while D changes to addi.
        OpD = 6'h0D;
        step("ori");
        StallE = 1'b1; OpD = 6'h08;
        for (int i = 0; i < 3; i++) step("stall_hold");
        chk("stall_zx", {31'd0, ImmZeroExtE}, 32'h1);
        FlushE = 1'b1;
        step("flush_and_stall");
        chk("flush_alu", {28'd0, ALUControlE}, 32'h0);
        FlushE = 1'b0; StallE = 1'b0;

        // beq / j.
        OpD = 6'h04;
        check_d("beq_d");
        chk("beq_branchd", {31'd0, BranchD}, 32'h1);
        step("beq_e");
        OpD = 6'h02;
        check_d("j_d");
        chk("j_jumpd", {31'd0, JumpD}, 32'h1);
        step("j_e");

        // Illegal encodings, then a flush clears them.
        OpD = 6'h00; FunctD = 6'h08;
        step("bad_funct");
        chk("bad_funct_alu", {28'd0, ALUControlE}, 32'hF);
        OpD = 6'h3F;
        step("bad_op");
        chk("bad_op_writes", {29'd0, RegWriteE, MemWriteE, MemtoRegE}, 32'h0);
        FlushE = 1'b1;
        step("bad_flush");
        FlushE = 1'b0;

        // All six R-type functs back to back.
        OpD = 6'h00;
        for (int i = 0; i < 6; i++) begin
            FunctD = sweep_fn[i];
            step("sweep");
            chk("sweep_alu", {28'd0, ALUControlE}, {28'd0, sweep_alu[i]});
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            reset  = 1'b0;
            OpD    = ($urandom_range(0, 9) == 9) ? 6'($urandom) : op_tab[$urandom_range(0, 8)];
            FunctD = ($urandom_range(0, 1) == 1) ? 6'($urandom) : rfn_tab[$urandom_range(0, 7)];
            StallE = ($urandom_range(0, 3) == 0);
            FlushE = ($urandom_range(0, 7) == 0);
            check_d("rnd_d");
            if ($urandom_range(0, 24) == 0) begin
                #1 reset = 1'b1;
                #1 e_exp = BUBBLE;
                check_e("rnd_arst");
            end
            step("rnd_e");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_idex.md
Name: alu_ctrl_idex

Overview:
- Producer end of the ALUControlE interface.
- Decodes the D-stage opcode/funct into main control and a 4-bit ALU operation code, then registers them into the E stage through the ID/EX control pipeline register.
- Supports flush (bubble insertion) and stall (hold).
- Sits between the hazard unit/decode stage and the E-stage ALU and datapath muxes.

Parameters:
- ALUCTRL_W, 4, width of the ALU operation code; fixed at 4 for the current ALU.
- BUBBLE_ALU, 4'b0000, ALUControlE value loaded on reset or flush.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- OpD  in  6  instruction bits [31:26]
- FunctD  in  6  instruction bits [5:0]
- StallE  in  1  hold all E-stage registers
- FlushE  in  1  load bubble into E-stage registers
- BranchD  out  1  combinational, beq decoded
- JumpD  out  1  combinational, j decoded
- RegWriteE  out  1  registered
- MemtoRegE  out  1  registered
- MemWriteE  out  1  registered
- ALUSrcE  out  1  registered, 1 selects immediate
- RegDstE  out  1  registered, 1 selects rd
- ImmZeroExtE  out  1  registered, 1 for andi/ori
- ALUControlE  out  ALUCTRL_W  registered ALU operation code

Behaviour:
- ALU codes:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
  - UNDEF 1111; the ALU yields 0 for this code.
- R-type (Op 000000), all with RegWrite=1, RegDst=1:
  - funct 100000/100001 -> ADD
  - 100010/100011 -> SUB
  - 100100 -> AND
  - 100101 -> OR
  - 100111 -> NOR
  - 101010 -> SLT
  - any other funct -> UNDEF with RegWrite=0.
- I-type:
  - lw 100011: ADD, RegWrite, MemtoReg, ALUSrc.
  - sw 101011: ADD, MemWrite, ALUSrc.
  - beq 000100: SUB, BranchD.
  - addi 001000: ADD, RegWrite, ALUSrc.
  - slti 001010: SLT, RegWrite, ALUSrc.
  - andi 001100: AND, RegWrite, ALUSrc, ImmZeroExt.
  - ori 001101: OR, RegWrite, ALUSrc, ImmZeroExt.
  - j 000010: JumpD, no writes, ALU code ADD.
- Unknown opcode: every write/enable 0; ALU code UNDEF.
- Decode is purely combinational in D; BranchD/JumpD have zero latency.
- E-stage register, 1-cycle latency, updated on rising clk. Priority order:
  1. reset (async): all registered outputs 0, ALUControlE = BUBBLE_ALU.
  2. FlushE: same bubble values as reset.
  3. StallE: hold current values.
  4. Otherwise: load D-stage decode.
- FlushE and StallE both high: flush wins.
- Reset asserted mid-operation clears outputs immediately, without waiting for a clock edge. Its deassertion takes effect at the next edge.
- A bubble must never assert RegWriteE or MemWriteE.

Optional Feature:
- Macro: ALU_CTRL_ILLEGAL_EN.
- Defined:
  - Adds output IllegalE (1 bit, registered): 1 for an unknown opcode or an undefined R-type funct.
  - Follows the same reset/flush/stall rules; bubble value 0.
- Undefined: the port is absent and illegal encodings silently decode as no-op as above.

Test Plan:
- Reset:
  - Assert reset between clock edges -> all E outputs 0 and ALUControlE=0000 immediately.
  - Release reset with OpD=000000, FunctD=100010 -> after next edge ALUControlE=0110, RegWriteE=1, RegDstE=1.
- lw then sw across two cycles -> E: ALUControlE=0010, MemtoRegE=1, RegWriteE=1, ALUSrcE=1; next cycle MemWriteE=1, RegWriteE=0.
- Stall/flush:
  - OpD=001101 (ori), StallE=1 for 3 cycles while OpD changes to 001000 -> E outputs hold prior values throughout.
  - Then FlushE=1 and StallE=1 together -> bubble (all 0, ALUControlE=0000).
- beq and j:
  - OpD=000100 -> BranchD=1 in the same cycle; after the edge ALUControlE=0110, RegWriteE=0.
  - OpD=000010 -> JumpD=1, MemWriteE=0.
- Illegal encodings:
  - R-type funct 001000 -> ALUControlE=1111, RegWriteE=0.
  - OpD=111111 -> ALUControlE=1111, all writes 0.
  - With ALU_CTRL_ILLEGAL_EN defined, IllegalE=1 in both cases and 0 after a flush.
- Sweep all six R-type ALU functs back-to-back (no stall) -> ALUControlE sequence 0010, 0110, 0000, 0001, 1100, 0111, each one cycle after its D-stage instruction.
